// File: rtl/dbi_tx_arb.sv
// Two-requester round-robin arbiter for the DBI TX PHY; grants are held for a whole transaction.
// Latency: 1-cycle arbitration in IDLE, then combinational pass-through; backpressure from dtp_tx_rdy_i goes to the owner only.
module dbi_tx_arb #(
  parameter int DBI_IF_D_W = 8,
  parameter int STARVE_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_vld_i,
  input  logic                  s0_hrst_i,
  input  logic [DBI_IF_D_W-1:0] s0_cmd_typ_i,
  input  logic [DBI_IF_D_W-1:0] s0_cmd_dat_i,
  input  logic                  s0_last_i,
  input  logic                  s0_no_dat_i,
  output logic                  s0_rdy_o,
  input  logic                  s1_vld_i,
  input  logic                  s1_hrst_i,
  input  logic [DBI_IF_D_W-1:0] s1_cmd_typ_i,
  input  logic [DBI_IF_D_W-1:0] s1_cmd_dat_i,
  input  logic                  s1_last_i,
  input  logic                  s1_no_dat_i,
  output logic                  s1_rdy_o,
  input  logic                  dtp_tx_rdy_i,
  output logic                  dtp_dbi_hrst_o,
  output logic                  dtp_tx_last_o,
  output logic                  dtp_tx_no_dat_o,
  output logic                  dtp_tx_vld_o,
  output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_o,
  output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_o,
  output logic [1:0]            grant_o,
  output logic                  busy_o,
  output logic                  txn_done_o,
  output logic                  starve_o
);

  localparam int CNT_W = $clog2(STARVE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr_ptr;
  logic             w_rr_ptr_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_txn_done;
  logic             w_hs;
  logic             w_end;
  logic             w_other_vld;

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_hs             = 1'b0;
    w_end            = 1'b0;
    w_other_vld      = 1'b0;
    s0_rdy_o         = 1'b0;
    s1_rdy_o         = 1'b0;
    dtp_dbi_hrst_o   = 1'b0;
    dtp_tx_last_o    = 1'b0;
    dtp_tx_no_dat_o  = 1'b0;
    dtp_tx_vld_o     = 1'b0;
    dtp_tx_cmd_typ_o = '0;
    dtp_tx_cmd_dat_o = '0;
    grant_o          = 2'b00;
    busy_o           = 1'b0;
    // Outputs are forced quiet while rst is high, even before the state register clears.
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (s0_vld_i && s1_vld_i) w_state_nxt = r_rr_ptr ? GNT1 : GNT0;
          else if (s0_vld_i)        w_state_nxt = GNT0;
          else if (s1_vld_i)        w_state_nxt = GNT1;
        end
        GNT0: begin
          grant_o          = 2'b01;
          busy_o           = 1'b1;
          dtp_tx_vld_o     = s0_vld_i;
          dtp_dbi_hrst_o   = s0_hrst_i;
          dtp_tx_last_o    = s0_last_i;
          dtp_tx_no_dat_o  = s0_no_dat_i;
          dtp_tx_cmd_typ_o = s0_cmd_typ_i;
          dtp_tx_cmd_dat_o = s0_cmd_dat_i;
          s0_rdy_o         = dtp_tx_rdy_i;
          w_hs             = s0_vld_i & dtp_tx_rdy_i;
          w_end            = w_hs & (s0_last_i | s0_hrst_i);
          w_other_vld      = s1_vld_i;
          if (w_end) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = 1'b1;
          end
        end
        GNT1: begin
          grant_o          = 2'b10;
          busy_o           = 1'b1;
          dtp_tx_vld_o     = s1_vld_i;
          dtp_dbi_hrst_o   = s1_hrst_i;
          dtp_tx_last_o    = s1_last_i;
          dtp_tx_no_dat_o  = s1_no_dat_i;
          dtp_tx_cmd_typ_o = s1_cmd_typ_i;
          dtp_tx_cmd_dat_o = s1_cmd_dat_i;
          s1_rdy_o         = dtp_tx_rdy_i;
          w_hs             = s1_vld_i & dtp_tx_rdy_i;
          w_end            = w_hs & (s1_last_i | s1_hrst_i);
          w_other_vld      = s0_vld_i;
          if (w_end) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = 1'b0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_wait_cnt <= '0;
      r_txn_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_txn_done <= w_end;
      // Clearing on the way to IDLE takes priority over counting the final cycle.
      if (w_state_nxt == IDLE)
        r_wait_cnt <= '0;
      else if (w_other_vld && (r_wait_cnt != CNT_MAX))
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign txn_done_o = r_txn_done & ~rst;
  assign starve_o   = (r_wait_cnt == CNT_MAX) & ~rst;

endmodule

// File: tb/tb_dbi_tx_arb.sv
// Directed bench for dbi_tx_arb: expected PHY beats are queued by the stimulus and
// popped by a negedge monitor on every PHY handshake; control outputs are checked inline.
module tb_dbi_tx_arb;

  logic       clk;
  logic       rst;
  logic       s0_vld_i, s0_hrst_i, s0_last_i, s0_no_dat_i, s0_rdy_o;
  logic [7:0] s0_cmd_typ_i, s0_cmd_dat_i;
  logic       s1_vld_i, s1_hrst_i, s1_last_i, s1_no_dat_i, s1_rdy_o;
  logic [7:0] s1_cmd_typ_i, s1_cmd_dat_i;
  logic       dtp_tx_rdy_i;
  logic       dtp_dbi_hrst_o, dtp_tx_last_o, dtp_tx_no_dat_o, dtp_tx_vld_o;
  logic [7:0] dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o;
  logic [1:0] grant_o;
  logic       busy_o, txn_done_o, starve_o;

  dbi_tx_arb #(.DBI_IF_D_W(8), .STARVE_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .s0_vld_i(s0_vld_i), .s0_hrst_i(s0_hrst_i), .s0_cmd_typ_i(s0_cmd_typ_i),
    .s0_cmd_dat_i(s0_cmd_dat_i), .s0_last_i(s0_last_i), .s0_no_dat_i(s0_no_dat_i),
    .s0_rdy_o(s0_rdy_o),
    .s1_vld_i(s1_vld_i), .s1_hrst_i(s1_hrst_i), .s1_cmd_typ_i(s1_cmd_typ_i),
    .s1_cmd_dat_i(s1_cmd_dat_i), .s1_last_i(s1_last_i), .s1_no_dat_i(s1_no_dat_i),
    .s1_rdy_o(s1_rdy_o),
    .dtp_tx_rdy_i(dtp_tx_rdy_i),
    .dtp_dbi_hrst_o(dtp_dbi_hrst_o), .dtp_tx_last_o(dtp_tx_last_o),
    .dtp_tx_no_dat_o(dtp_tx_no_dat_o), .dtp_tx_vld_o(dtp_tx_vld_o),
    .dtp_tx_cmd_typ_o(dtp_tx_cmd_typ_o), .dtp_tx_cmd_dat_o(dtp_tx_cmd_dat_o),
    .grant_o(grant_o), .busy_o(busy_o), .txn_done_o(txn_done_o), .starve_o(starve_o)
  );

  typedef struct packed {
    logic [1:0] src;
    logic       hrst;
    logic       last;
    logic       no_dat;
    logic [7:0] typ;
    logic [7:0] dat;
  } beat_t;

  beat_t      exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] t1_dat [4] = '{8'h00, 8'h00, 8'h01, 8'h3F};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {6'd0, grant_o, busy_o, txn_done_o, starve_o, s0_rdy_o, s1_rdy_o, dtp_tx_vld_o,
            dtp_tx_last_o, dtp_dbi_hrst_o, dtp_tx_no_dat_o, dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o};
  endfunction

  task automatic push(input logic [1:0] src, input logic hrst, input logic last,
                      input logic no_dat, input logic [7:0] typ, input logic [7:0] dat);
    beat_t b;
    b.src = src; b.hrst = hrst; b.last = last; b.no_dat = no_dat; b.typ = typ; b.dat = dat;
    exp_q.push_back(b);
  endtask

  task automatic set_s0(input logic vld, input logic hrst, input logic last, input logic no_dat,
                        input logic [7:0] typ, input logic [7:0] dat);
    s0_vld_i = vld; s0_hrst_i = hrst; s0_last_i = last; s0_no_dat_i = no_dat;
    s0_cmd_typ_i = typ; s0_cmd_dat_i = dat;
  endtask

  task automatic set_s1(input logic vld, input logic hrst, input logic last, input logic no_dat,
                        input logic [7:0] typ, input logic [7:0] dat);
    s1_vld_i = vld; s1_hrst_i = hrst; s1_last_i = last; s1_no_dat_i = no_dat;
    s1_cmd_typ_i = typ; s1_cmd_dat_i = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    beat_t a;
    beat_t e;
    if (!rst && dtp_tx_vld_o && dtp_tx_rdy_i) begin
      a.src = grant_o; a.hrst = dtp_dbi_hrst_o; a.last = dtp_tx_last_o;
      a.no_dat = dtp_tx_no_dat_o; a.typ = dtp_tx_cmd_typ_o; a.dat = dtp_tx_cmd_dat_o;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t", a, $time);
      end else begin
        e = exp_q.pop_front();
        chk("phy_beat", 32'(a), 32'(e));
      end
    end
  end

  initial begin
    rst = 1'b1;
    dtp_tx_rdy_i = 1'b1;
    set_s0(1, 0, 0, 0, 8'h00, 8'h00);
    set_s1(1, 0, 0, 0, 8'h00, 8'h00);
    step(); step();
    neg(); chk("reset_outs", outs_vec(), 32'd0);
    step();
    set_s0(0, 0, 0, 0, 8'h00, 8'h00);
    set_s1(0, 0, 0, 0, 8'h00, 8'h00);
    rst = 1'b0;
    neg(); chk("idle_outs", outs_vec(), 32'd0);
    step();

    // Single s1 transaction of four beats.
    for (int i = 0; i < 4; i++) push(2'b10, 0, (i == 3), 0, 8'h2A, t1_dat[i]);
    set_s1(1, 0, 0, 0, 8'h2A, t1_dat[0]);
    neg(); chk("t1_idle_grant", grant_o, 2'b00); chk("t1_idle_nopass", dtp_tx_vld_o, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_s1(1, 0, (i == 3), 0, 8'h2A, t1_dat[i]);
      neg(); chk("t1_grant", grant_o, 2'b10); chk("t1_s0_rdy", s0_rdy_o, 1'b0);
      step();
    end
    set_s1(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); chk("t1_done", txn_done_o, 1'b1); chk("t1_back_idle", {busy_o, grant_o}, 3'b000);
    step();
    neg(); chk("t1_done_pulse", txn_done_o, 1'b0);
    step();

    // Contention straight after reset: s0 first, s1 after one bubble, then s0 again.
    rst = 1'b1; step(); rst = 1'b0;
    push(2'b01, 0, 0, 0, 8'h11, 8'hA0);
    push(2'b01, 0, 1, 0, 8'h11, 8'hA1);
    push(2'b10, 0, 0, 0, 8'h22, 8'hB0);
    push(2'b10, 0, 1, 0, 8'h22, 8'hB1);
    push(2'b01, 0, 1, 0, 8'h33, 8'hC0);
    push(2'b10, 1, 0, 1, 8'h44, 8'hD0);
    set_s0(1, 0, 0, 0, 8'h11, 8'hA0);
    set_s1(1, 0, 0, 0, 8'h22, 8'hB0);
    neg(); chk("t2_arb_cycle", grant_o, 2'b00); step();
    neg(); chk("t2_s0_first", grant_o, 2'b01); chk("t2_s1_blocked", s1_rdy_o, 1'b0); step();
    set_s0(1, 0, 1, 0, 8'h11, 8'hA1);
    neg(); chk("t2_s0_hold", grant_o, 2'b01); step();
    set_s0(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); chk("t2_bubble", grant_o, 2'b00); chk("t2_done", txn_done_o, 1'b1); step();
    neg(); chk("t2_s1_next", grant_o, 2'b10); step();
    set_s1(1, 0, 1, 0, 8'h22, 8'hB1);
    neg(); step();
    set_s0(1, 0, 1, 0, 8'h33, 8'hC0);
    set_s1(1, 1, 0, 1, 8'h44, 8'hD0);
    neg(); chk("t2_idle2", grant_o, 2'b00); step();
    neg(); chk("t2_s0_again", grant_o, 2'b01); step();
    set_s0(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); chk("t2_idle3", grant_o, 2'b00); step();
    neg(); chk("t2_hrst_grant", grant_o, 2'b10); step();
    set_s1(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); chk("t2_hrst_single", {grant_o, txn_done_o}, 3'b001); step();

    // Lock: s0 drops vld mid-transaction while s1 waits.
    push(2'b01, 0, 0, 0, 8'h55, 8'h10);
    push(2'b01, 0, 1, 0, 8'h55, 8'h11);
    push(2'b10, 0, 1, 0, 8'h66, 8'hE0);
    set_s0(1, 0, 0, 0, 8'h55, 8'h10);
    set_s1(1, 0, 1, 0, 8'h66, 8'hE0);
    neg(); step();
    neg(); chk("t3_grant", grant_o, 2'b01); step();
    set_s0(0, 0, 0, 0, 8'h55, 8'h10);
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("t3_lock", {grant_o, s1_rdy_o, dtp_tx_vld_o}, 4'b0100);
      step();
    end
    set_s0(1, 0, 1, 0, 8'h55, 8'h11);
    neg(); chk("t3_resume", grant_o, 2'b01); step();
    set_s0(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); step();
    neg(); chk("t3_s1_grant", grant_o, 2'b10); step();
    set_s1(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); step();

    // Backpressure: PHY ready goes 1,0,0,1 while s0 owns the port.
    push(2'b01, 0, 0, 0, 8'h77, 8'h20);
    push(2'b01, 0, 1, 0, 8'h77, 8'h21);
    set_s0(1, 0, 0, 0, 8'h77, 8'h20);
    neg(); step();
    neg(); chk("t4_rdy1", s0_rdy_o, 1'b1); step();
    set_s0(1, 0, 1, 0, 8'h77, 8'h21);
    dtp_tx_rdy_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      neg();
      chk("t4_rdy0", s0_rdy_o, 1'b0);
      chk("t4_stable", {dtp_tx_vld_o, dtp_tx_last_o, dtp_tx_cmd_dat_o}, {2'b11, 8'h21});
      step();
    end
    dtp_tx_rdy_i = 1'b1;
    neg(); chk("t4_rdy_back", s0_rdy_o, 1'b1); step();
    set_s0(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); chk("t4_done", txn_done_o, 1'b1); step();

    // Starvation: s0 streams 20 beats, then a last beat, with s1 waiting throughout.
    for (int i = 0; i <= 20; i++) push(2'b01, 0, (i == 20), 0, 8'h88, 8'(i));
    push(2'b10, 0, 1, 0, 8'h99, 8'hF0);
    set_s0(1, 0, 0, 0, 8'h88, 8'h00);
    neg(); step();
    set_s1(1, 0, 1, 0, 8'h99, 8'hF0);
    for (int i = 0; i <= 20; i++) begin
      set_s0(1, 0, (i == 20), 0, 8'h88, 8'(i));
      neg();
      chk("t5_grant", grant_o, 2'b01);
      if (i == 7)  chk("t5_starve_below", starve_o, 1'b0);
      if (i == 8)  chk("t5_starve_hit", starve_o, 1'b1);
      if (i == 20) chk("t5_starve_sat", starve_o, 1'b1);
      step();
    end
    set_s0(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); chk("t5_starve_clear", {starve_o, txn_done_o}, 2'b01); step();
    neg(); chk("t5_s1_grant", grant_o, 2'b10); step();
    set_s1(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); chk("t5_idle_starve", starve_o, 1'b0); step();

    // Reset in the middle of an s1 transaction, then a simultaneous request.
    push(2'b10, 0, 0, 0, 8'hAB, 8'h01);
    push(2'b01, 0, 1, 0, 8'hCD, 8'h5A);
    push(2'b10, 0, 1, 0, 8'hAB, 8'h02);
    set_s1(1, 0, 0, 0, 8'hAB, 8'h01);
    neg(); step();
    neg(); chk("t6_grant", grant_o, 2'b10); step();
    set_s1(1, 0, 0, 0, 8'hAB, 8'h02);
    rst = 1'b1;
    neg(); chk("t6_rst_outs", outs_vec(), 32'd0); step();
    rst = 1'b0;
    set_s0(1, 0, 1, 0, 8'hCD, 8'h5A);
    set_s1(1, 0, 1, 0, 8'hAB, 8'h02);
    neg(); chk("t6_post_rst", outs_vec(), 32'd0); step();
    neg(); chk("t6_s0_pref", grant_o, 2'b01); step();
    set_s0(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); step();
    neg(); chk("t6_s1_grant", grant_o, 2'b10); step();
    set_s1(0, 0, 0, 0, 8'h00, 8'h00);
    neg(); step();
    neg(); chk("beats_left", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
